dither_pixel_datapath: RTL and testbench
========================================

DITHER_PIXEL_DATAPATH -- requirements
Module: dither_pixel_datapath

Interface
REQ-001 Parameter IMAGEX, default 256: image width in pixels; SHALL be a power of two.
REQ-002 Parameter IMAGEY, default 256: image height in pixels.
REQ-003 Parameter ADDR_W, default 16: pixel address width, equal to log2(IMAGEX*IMAGEY).
REQ-004 Parameter THRESH, default 128: quantisation threshold.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 store_old_p  in  1  phase strobe: fetch the old pixel.
REQ-008 compare_and_store_n  in  1  phase strobe: quantise the pixel.
REQ-009 compute_fin  in  5  one-hot phase strobes: error diffusion and commit.
REQ-010 png_idx  in  ADDR_W  current pixel address; stable for all phases of one pixel.
REQ-011 rd_en, rd_addr  out  1, ADDR_W  pixel SRAM read request.
REQ-012 rd_data  in  8  pixel SRAM read data; valid one cycle after rd_en.
REQ-013 wr_en, wr_addr, wr_data  out  1, ADDR_W, 8  pixel SRAM write.
REQ-014 frame_done  out  1  one-cycle pulse when the last pixel commits.
REQ-015 proto_err  out  1  sticky flag: illegal strobe combination seen.
REQ-016 white_cnt  out  ADDR_W+1  count of pixels written as 255.

Function
REQ-017 Pixel coordinates SHALL be x = png_idx[log2(IMAGEX)-1:0] and y = png_idx >> log2(IMAGEX).
REQ-018 rd_en SHALL equal store_old_p combinationally, with rd_addr = png_idx.
REQ-019 The block SHALL hold two row buffers, cur and nxt, each IMAGEX signed 13-bit accumulators in flops; each accumulator holds error x16.
REQ-020 In the compare_and_store_n cycle:
- adj = rd_data + (cur[x] >>> 4), arithmetic shift (floor), clamped to 0..255.
- new = 255 if adj >= THRESH, else 0.
- e = adj - new, a signed 9-bit value registered into e_q.
REQ-021 The cycle after compare_and_store_n, wr_en SHALL be 1 for exactly one cycle, with wr_addr = png_idx and wr_data = new, both registered.
REQ-022 compute_fin[0]: cur[x+1] += 7*e_q, only if x < IMAGEX-1.
REQ-023 compute_fin[1]: nxt[x-1] += 3*e_q, only if x > 0 and y < IMAGEY-1.
REQ-024 compute_fin[2]: nxt[x] += 5*e_q, only if y < IMAGEY-1.
REQ-025 compute_fin[3]: nxt[x+1] += 1*e_q, only if x < IMAGEX-1 and y < IMAGEY-1.
REQ-026 compute_fin[4]: cur[x] SHALL be cleared to 0.
- If x == IMAGEX-1, the cur and nxt roles SHALL swap via a row-select bit, effective for the next pixel.
REQ-027 frame_done SHALL be 1 in the cycle after the compute_fin[4] cycle whose png_idx == IMAGEX*IMAGEY-1.
- After this event the row-select bit SHALL return to 0.
- All accumulators SHALL then read 0 without any additional clearing.
REQ-028 Accumulator addition SHALL saturate at -4096 and +4095.
REQ-029 Any cycle with two or more of {store_old_p, compare_and_store_n, compute_fin[4:0]} high SHALL:
- set proto_err;
- suppress every buffer, e_q and write update in that cycle.
REQ-030 A strobe SHALL act only in its own cycle; strobes arriving out of order SHALL still execute using the current e_q, without error.
REQ-031 Idle cycles (all strobes low) SHALL change no state.

Reset
REQ-032 On rst, every accumulator, e_q, the row-select bit, wr_en, wr_addr, wr_data, frame_done, proto_err and white_cnt SHALL be 0 on the next edge.
REQ-033 rst asserted mid-pixel or mid-frame SHALL abandon the frame with no pending write issued.
REQ-034 rst SHALL be the only means of clearing proto_err.

Configuration
REQ-035 Macro DITHER_WHITE_CNT_EN, when defined:
- white_cnt SHALL increment on every wr_en with wr_data == 255.
- white_cnt SHALL wrap at 2^(ADDR_W+1).
- white_cnt SHALL clear on rst and on frame_done.
REQ-036 Macro DITHER_WHITE_CNT_EN, when undefined: white_cnt SHALL be tied to 0 and no counter logic SHALL be synthesised.

Verification
REQ-037 Reset: assert rst with random strobes -> all outputs 0 the next cycle and all accumulators 0.
REQ-038 Pixel (0,0), rd_data=200, zero error -> wr_data=255 at wr_addr 0, e=-55, cur[1]=-385, nxt[0]=-275, nxt[1]=-55.
REQ-039 Pixel (1,0) following REQ-038, rd_data=100 -> adj = 100 + (-25) = 75, wr_data=0, e=75.
REQ-040 Right edge x=255, y=0, e=20 -> cur/nxt index 256 untouched, nxt[254]=60, nxt[255]=100, row select toggles after compute_fin[4].
REQ-041 Full 256x256 frame of constant 128 -> frame_done pulses once after png_idx=65535, all accumulators 0 afterwards, white_cnt equals the number of 255 writes (DITHER_WHITE_CNT_EN defined).
REQ-042 compute_fin=5'b00011 -> proto_err=1 and no accumulator change; rd_data=250 with cur[x]=+160 -> adj clamped to 255, wr_data=255, e=0.

Source files
------------

// File: rtl/dither_pixel_datapath.sv
// dither_pixel_datapath: Floyd-Steinberg error-diffusion pixel datapath with two x16 error row buffers.
// Define DITHER_WHITE_CNT_EN to build the white-pixel counter; otherwise white_cnt is tied to 0.
module dither_pixel_datapath #(
  parameter int IMAGEX = 256,
  parameter int IMAGEY = 256,
  parameter int ADDR_W = 16,
  parameter int THRESH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store_old_p,
  input  logic              compare_and_store_n,
  input  logic [4:0]        compute_fin,
  input  logic [ADDR_W-1:0] png_idx,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              proto_err,
  output logic [ADDR_W:0]   white_cnt
);
  localparam int LX = $clog2(IMAGEX);
  localparam logic [LX-1:0] XMAX = '1;
  localparam logic [ADDR_W-1:0] YMAX = ADDR_W'(IMAGEY - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMAGEX * IMAGEY - 1);
  localparam logic [8:0] TH = 9'(THRESH);

  logic signed [12:0] acc [2][IMAGEX];
  logic               row_sel;
  logic signed [8:0]  e_q;
  logic [LX-1:0]      x, xp, xm;
  logic [ADDR_W-1:0]  y;
  logic               ok, multi, last_px, x_edge, y_edge;
  logic signed [12:0] cur_x, e13, m7, m3, m5;
  logic signed [13:0] cx, adj_raw;
  logic [7:0]         adj, nw;
  logic signed [8:0]  e;

  assign rd_en   = store_old_p;
  assign rd_addr = png_idx;
  assign x       = png_idx[LX-1:0];
  assign y       = png_idx >> LX;
  assign xp      = x + LX'(1);
  assign xm      = x - LX'(1);
  assign x_edge  = x == XMAX;
  assign y_edge  = y >= YMAX;
  assign last_px = png_idx == LAST;
  assign multi   = $countones({store_old_p, compare_and_store_n, compute_fin}) > 1;
  assign ok      = !multi;

  // Accumulators hold error x16; the arithmetic shift floors back to pixel units.
  assign cur_x   = acc[row_sel][x];
  assign cx      = {cur_x[12], cur_x};
  assign adj_raw = $signed({6'b0, rd_data}) + (cx >>> 4);
  assign adj     = adj_raw[13] ? 8'd0 : |adj_raw[12:8] ? 8'd255 : adj_raw[7:0];
  assign nw      = {1'b0, adj} >= TH ? 8'hFF : 8'h00;
  assign e       = $signed({1'b0, adj}) - $signed({1'b0, nw});

  assign e13 = {{4{e_q[8]}}, e_q};
  assign m7  = (e13 <<< 3) - e13;
  assign m3  = (e13 <<< 1) + e13;
  assign m5  = (e13 <<< 2) + e13;

  function automatic logic signed [12:0] sat(input logic signed [12:0] a, input logic signed [12:0] d);
    logic signed [13:0] s;
    s = {a[12], a} + {d[12], d};
    return (s[13] != s[12]) ? (s[13] ? 13'sh1000 : 13'sh0FFF) : s[12:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < IMAGEX; i++)
          acc[b][i] <= '0;
      e_q        <= '0;
      row_sel    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      wr_en      <= ok & compare_and_store_n;
      frame_done <= ok & compute_fin[4] & last_px;
      if (multi) proto_err <= 1'b1;
      if (ok && compare_and_store_n) begin
        e_q     <= e;
        wr_addr <= png_idx;
        wr_data <= nw;
      end
      if (ok) begin
        if (compute_fin[0] && !x_edge)
          acc[row_sel][xp] <= sat(acc[row_sel][xp], m7);
        if (compute_fin[1] && x != '0 && !y_edge)
          acc[~row_sel][xm] <= sat(acc[~row_sel][xm], m3);
        if (compute_fin[2] && !y_edge)
          acc[~row_sel][x] <= sat(acc[~row_sel][x], m5);
        if (compute_fin[3] && !x_edge && !y_edge)
          acc[~row_sel][xp] <= sat(acc[~row_sel][xp], e13);
        if (compute_fin[4]) begin
          acc[row_sel][x] <= '0;
          row_sel <= last_px ? 1'b0 : x_edge ? ~row_sel : row_sel;
        end
      end
    end
  end

`ifdef DITHER_WHITE_CNT_EN
  always_ff @(posedge clk)
    if (rst || frame_done) white_cnt <= '0;
    else if (wr_en && wr_data == 8'hFF) white_cnt <= white_cnt + (ADDR_W + 1)'(1);
`else
  assign white_cnt = '0;
`endif
endmodule

// File: tb/tb_dither_pixel_datapath.sv
// tb_dither_pixel_datapath: directed checks of the dither datapath on a 256x4 image plus a full-frame reference run.
module tb_dither_pixel_datapath;
  localparam int IX = 256, IY = 4, AW = 10;
  logic clk = 1'b0, rst;
  logic store_old_p, compare_and_store_n;
  logic [4:0] compute_fin;
  logic [AW-1:0] png_idx, rd_addr, wr_addr;
  logic rd_en, wr_en, frame_done, proto_err;
  logic [7:0] rd_data, wr_data;
  logic [AW:0] white_cnt;
  int checks = 0, errors = 0, fd_cnt = 0;

  dither_pixel_datapath #(.IMAGEX(IX), .IMAGEY(IY), .ADDR_W(AW), .THRESH(128)) dut (
    .clk(clk), .rst(rst), .store_old_p(store_old_p), .compare_and_store_n(compare_and_store_n),
    .compute_fin(compute_fin), .png_idx(png_idx), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .proto_err(proto_err), .white_cnt(white_cnt)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [31:0] acc(input int b, input int i);
    return dut.acc[b][i];
  endfunction

  function automatic int nz();
    int n = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < IX; i++)
        if (dut.acc[b][i] != 0) n++;
    return n;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    store_old_p = 1'($urandom);
    compare_and_store_n = 1'($urandom);
    compute_fin = 5'($urandom);
    step();
    store_old_p = 1'b0;
    compute_fin = '0;
    compare_and_store_n = 1'b1;
    rd_data = 8'd200;
    step();
    rst = 1'b0;
    compare_and_store_n = 1'b0;
  endtask

  task automatic pixel(input int idx, input int rd);
    png_idx = AW'(idx);
    store_old_p = 1'b1;
    step();
    store_old_p = 1'b0;
    compare_and_store_n = 1'b1;
    rd_data = 8'(rd);
    step();
    compare_and_store_n = 1'b0;
  endtask

  task automatic fin(input int k);
    compute_fin = 5'(1 << k);
    step();
    compute_fin = '0;
  endtask

  int m[2][IX];
  int rs, mw, x, y, adj, nw, e, fd0;

  function automatic int sat(input int v);
    return v > 4095 ? 4095 : v < -4096 ? -4096 : v;
  endfunction

  initial begin
    rst = 1'b1; store_old_p = 0; compare_and_store_n = 0; compute_fin = 0; png_idx = 0; rd_data = 0;
    pixel(0, 200);
    fin(0);
    do_reset();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_white_cnt", white_cnt, 0);
    chk("rst_row_sel", dut.row_sel, 0);
    chk("rst_e_q", $signed(dut.e_q), 0);
    chk("rst_acc_nz", nz(), 0);

    png_idx = AW'(5); store_old_p = 1'b1; #1;
    chk("rd_en_hi", rd_en, 1);
    chk("rd_addr", rd_addr, 5);
    store_old_p = 1'b0; #1;
    chk("rd_en_lo", rd_en, 0);

    pixel(0, 200);
    chk("p00_wr_en", wr_en, 1);
    chk("p00_wr_addr", wr_addr, 0);
    chk("p00_wr_data", wr_data, 255);
    chk("p00_e_q", $signed(dut.e_q), -55);
    fin(0);
    chk("p00_wr_en_drop", wr_en, 0);
    for (int k = 1; k < 5; k++) fin(k);
    chk("p00_cur1", acc(0, 1), -385);
    chk("p00_nxt0", acc(1, 0), -275);
    chk("p00_nxt1", acc(1, 1), -55);
    chk("p00_cur0", acc(0, 0), 0);

    pixel(1, 100);
    chk("p10_wr_addr", wr_addr, 1);
    chk("p10_wr_data", wr_data, 0);
    chk("p10_e_q", $signed(dut.e_q), 75);
    for (int k = 0; k < 5; k++) fin(k);
    chk("p10_cur2", acc(0, 2), 525);
    chk("p10_nxt0", acc(1, 0), -50);
    chk("p10_nxt1", acc(1, 1), 320);
    chk("p10_nxt2", acc(1, 2), 75);
    chk("p10_cur1", acc(0, 1), 0);

    pixel(255, 20);
    chk("edge_wr_addr", wr_addr, 255);
    chk("edge_e_q", $signed(dut.e_q), 20);
    for (int k = 0; k < 4; k++) fin(k);
    chk("edge_nxt254", acc(1, 254), 60);
    chk("edge_nxt255", acc(1, 255), 100);
    chk("edge_cur0_nowrap", acc(0, 0), 0);
    chk("edge_nxt0_nowrap", acc(1, 0), -50);
    chk("edge_row_sel_pre", dut.row_sel, 0);
    fin(4);
    chk("edge_row_sel_post", dut.row_sel, 1);
    chk("edge_frame_done", frame_done, 0);

    png_idx = AW'(259);
    compute_fin = 5'b00011;
    step();
    compute_fin = '0;
    chk("illegal_proto_err", proto_err, 1);
    chk("illegal_nxt4", acc(1, 4), 0);
    chk("illegal_cur2", acc(0, 2), 525);
    store_old_p = 1'b1; compare_and_store_n = 1'b1; rd_data = 8'd0;
    step();
    store_old_p = 1'b0; compare_and_store_n = 1'b0;
    chk("illegal_no_wr", wr_en, 0);
    chk("illegal_e_q", $signed(dut.e_q), 20);
    step();
    chk("proto_err_sticky", proto_err, 1);

    do_reset();
    chk("rst_clears_proto", proto_err, 0);
    chk("rst_no_wr", wr_en, 0);
    pixel(0, 127);
    chk("sat_e_pos", $signed(dut.e_q), 127);
    fin(0);
    chk("sat_step1", acc(0, 1), 889);
    for (int k = 0; k < 4; k++) fin(0);
    chk("sat_pos", acc(0, 1), 4095);
    pixel(0, 128);
    chk("sat_e_neg", $signed(dut.e_q), -127);
    fin(0);
    chk("sat_down1", acc(0, 1), 3206);
    for (int k = 0; k < 9; k++) fin(0);
    chk("sat_neg", acc(0, 1), -4096);

    do_reset();
    pixel(0, 32);
    fin(2);
    chk("clamp_seed", acc(1, 0), 160);
    png_idx = AW'(255);
    fin(4);
    chk("clamp_row_sel", dut.row_sel, 1);
    pixel(256, 250);
    chk("clamp_wr_data", wr_data, 255);
    chk("clamp_wr_addr", wr_addr, 256);
    chk("clamp_e_q", $signed(dut.e_q), 0);
    chk("ooo_no_err", proto_err, 0);
    chk("fd_early", fd_cnt, 0);

    do_reset();
    for (int b = 0; b < 2; b++) for (int i = 0; i < IX; i++) m[b][i] = 0;
    rs = 0; mw = 0; fd0 = fd_cnt;
    for (int idx = 0; idx < IX * IY; idx++) begin
      x = idx % IX; y = idx / IX;
      adj = 128 + (m[rs][x] >>> 4);
      adj = adj < 0 ? 0 : adj > 255 ? 255 : adj;
      nw = adj >= 128 ? 255 : 0;
      e = adj - nw;
      if (nw == 255) mw++;
      if (x < IX - 1) m[rs][x + 1] = sat(m[rs][x + 1] + 7 * e);
      if (x > 0 && y < IY - 1) m[1 - rs][x - 1] = sat(m[1 - rs][x - 1] + 3 * e);
      if (y < IY - 1) m[1 - rs][x] = sat(m[1 - rs][x] + 5 * e);
      if (x < IX - 1 && y < IY - 1) m[1 - rs][x + 1] = sat(m[1 - rs][x + 1] + e);
      m[rs][x] = 0;
      if (x == IX - 1) rs = 1 - rs;
      pixel(idx, 128);
      chk("frame_wr_data", wr_data, nw);
      for (int k = 0; k < 5; k++) fin(k);
    end
    chk("frame_done_last", frame_done, 1);
`ifdef DITHER_WHITE_CNT_EN
    chk("frame_white_cnt", white_cnt, mw);
`else
    chk("frame_white_cnt", white_cnt, 0);
`endif
    step();
    chk("frame_done_once", fd_cnt - fd0, 1);
    chk("frame_done_drop", frame_done, 0);
    chk("frame_acc_zero", nz(), 0);
    chk("frame_row_sel", dut.row_sel, 0);
    chk("frame_white_clr", white_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
